// File: rtl/datapath_regfile.sv
// Register file, operand muxing and status register for the datapath.
// Feeds buses A/B to the function unit and writes back F or memory data.
module datapath_regfile #(
  parameter int WIDTH        = 16,
  parameter int ADDR_W       = 3,
  parameter int R0_HARDWIRED = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RW,
  input  logic [ADDR_W-1:0] DA,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  input  logic              MB,
  input  logic [WIDTH-1:0]  CONST_IN,
  input  logic              MD,
  input  logic [WIDTH-1:0]  F_DATA,
  input  logic [WIDTH-1:0]  DATA_IN,
  input  logic              SL,
  input  logic              V_IN,
  input  logic              C_IN,
  input  logic              N_IN,
  input  logic              Z_IN,
  output logic [WIDTH-1:0]  BUS_A,
  output logic [WIDTH-1:0]  BUS_B,
  output logic [WIDTH-1:0]  DATA_OUT,
  output logic [3:0]        STATUS
);

  localparam int NREG = 2 ** ADDR_W;
  localparam bit HW0  = (R0_HARDWIRED != 0);

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Write-back source select and write qualification (R0 may be read-only).
  always_comb begin
    wdata = MD ? DATA_IN : F_DATA;
    wr_en = RW && !(HW0 && (DA == '0));
  end

  // Register array: async clear, one write per rising edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[DA] <= wdata;
    end
  end

  // Combinational reads, no bypass; hardwired R0 reads zero.
  always_comb begin
    rd_a = regs[AA];
    rd_b = regs[BA];
    if (HW0 && (AA == '0)) rd_a = '0;
    if (HW0 && (BA == '0)) rd_b = '0;
  end

  // Operand buses and memory write data.
  always_comb begin
    BUS_A    = rd_a;
    DATA_OUT = rd_b;
    BUS_B    = MB ? CONST_IN : rd_b;
  end

  // Status register {V,C,N,Z}, loaded independently of register writes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      STATUS <= 4'b0000;
    end else if (SL) begin
      STATUS <= {V_IN, C_IN, N_IN, Z_IN};
    end
  end

endmodule

// File: tb/tb_datapath_regfile.sv
// Directed bench for datapath_regfile.
// Two instances: R0 general-purpose and R0 hardwired to zero.
module tb_datapath_regfile;

  logic        clk;
  logic        rst_n;
  logic        rw;
  logic [2:0]  da;
  logic [2:0]  aa;
  logic [2:0]  ba;
  logic        mb;
  logic [15:0] const_in;
  logic        md;
  logic [15:0] f_data;
  logic [15:0] data_in;
  logic        sl;
  logic        v_in;
  logic        c_in;
  logic        n_in;
  logic        z_in;

  logic [15:0] bus_a;
  logic [15:0] bus_b;
  logic [15:0] data_out;
  logic [3:0]  status;
  logic [15:0] bus_a0;
  logic [15:0] bus_b0;
  logic [15:0] data_out0;
  logic [3:0]  status0;

  int tests;
  int fails;

  datapath_regfile #(.WIDTH(16), .ADDR_W(3), .R0_HARDWIRED(0)) u_dut (
    .CLK(clk), .RESET(rst_n), .RW(rw), .DA(da), .AA(aa), .BA(ba),
    .MB(mb), .CONST_IN(const_in), .MD(md), .F_DATA(f_data),
    .DATA_IN(data_in), .SL(sl), .V_IN(v_in), .C_IN(c_in),
    .N_IN(n_in), .Z_IN(z_in), .BUS_A(bus_a), .BUS_B(bus_b),
    .DATA_OUT(data_out), .STATUS(status)
  );

  datapath_regfile #(.WIDTH(16), .ADDR_W(3), .R0_HARDWIRED(1)) u_dut0 (
    .CLK(clk), .RESET(rst_n), .RW(rw), .DA(da), .AA(aa), .BA(ba),
    .MB(mb), .CONST_IN(const_in), .MD(md), .F_DATA(f_data),
    .DATA_IN(data_in), .SL(sl), .V_IN(v_in), .C_IN(c_in),
    .N_IN(n_in), .Z_IN(z_in), .BUS_A(bus_a0), .BUS_B(bus_b0),
    .DATA_OUT(data_out0), .STATUS(status0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if (bus_a !== 16'h0000 || bus_b !== 16'h0000 || data_out !== 16'h0000) begin
      fails++;
      $display("FAIL reset_init_bus got a=%h b=%h d=%h want 0000", bus_a, bus_b, data_out);
    end
    tests++;
    if (status !== 4'b0000) begin
      fails++;
      $display("FAIL reset_init_status got %b want 0000", status);
    end
    rst_n = 1'b1;
    rw = 1'b1; md = 1'b0; f_data = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      da = 3'(i);
      tick();
    end
    sl = 1'b1; {v_in, c_in, n_in, z_in} = 4'b1111;
    da = 3'd4;
    tick();
    aa = 3'd7;
    #1;
    tests++;
    if (bus_a !== 16'hFFFF || status !== 4'b1111) begin
      fails++;
      $display("FAIL reset_prefill got a=%h st=%b want ffff 1111", bus_a, status);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      aa = 3'(i);
      #0.1;
      tests++;
      if (bus_a !== 16'h0000) begin
        fails++;
        $display("FAIL reset_async_r%0d got %h want 0000", i, bus_a);
      end
    end
    tests++;
    if (status !== 4'b0000) begin
      fails++;
      $display("FAIL reset_async_status got %b want 0000", status);
    end
    aa = 3'd4;
    tick();
    tests++;
    if (bus_a !== 16'h0000 || status !== 4'b0000) begin
      fails++;
      $display("FAIL reset_hold got a=%h st=%b want 0000 0000", bus_a, status);
    end
    rw = 1'b0; sl = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    rw = 1'b1; da = 3'd3; md = 1'b0; f_data = 16'h1234;
    tick();
    rw = 1'b0; aa = 3'd3; ba = 3'd3; mb = 1'b0;
    #1;
    tests++;
    if (bus_a !== 16'h1234) begin
      fails++;
      $display("FAIL wr_bus_a got %h want 1234", bus_a);
    end
    tests++;
    if (bus_b !== 16'h1234) begin
      fails++;
      $display("FAIL wr_bus_b got %h want 1234", bus_b);
    end
    tests++;
    if (data_out !== 16'h1234) begin
      fails++;
      $display("FAIL wr_data_out got %h want 1234", data_out);
    end
  endtask

  task automatic test_hazard();
    rw = 1'b1; da = 3'd5; md = 1'b0; f_data = 16'h0001;
    tick();
    f_data = 16'h00AA; aa = 3'd5; ba = 3'd5; mb = 1'b0;
    #1;
    tests++;
    if (bus_a !== 16'h0001 || data_out !== 16'h0001) begin
      fails++;
      $display("FAIL hazard_before got a=%h d=%h want 0001", bus_a, data_out);
    end
    tick();
    rw = 1'b0;
    #1;
    tests++;
    if (bus_a !== 16'h00AA || bus_b !== 16'h00AA) begin
      fails++;
      $display("FAIL hazard_after got a=%h b=%h want 00aa", bus_a, bus_b);
    end
  endtask

  task automatic test_mux();
    mb = 1'b1; const_in = 16'h0007; ba = 3'd3;
    #1;
    tests++;
    if (bus_b !== 16'h0007) begin
      fails++;
      $display("FAIL mux_const got %h want 0007", bus_b);
    end
    tests++;
    if (data_out !== 16'h1234) begin
      fails++;
      $display("FAIL mux_data_out got %h want 1234", data_out);
    end
    rw = 1'b1; da = 3'd2; md = 1'b1; data_in = 16'hBEEF; f_data = 16'h1111;
    tick();
    rw = 1'b0; aa = 3'd2; mb = 1'b0; ba = 3'd2;
    #1;
    tests++;
    if (bus_a !== 16'hBEEF || bus_b !== 16'hBEEF) begin
      fails++;
      $display("FAIL mux_md got a=%h b=%h want beef", bus_a, bus_b);
    end
  endtask

  task automatic test_status();
    sl = 1'b1; {v_in, c_in, n_in, z_in} = 4'b1010;
    tick();
    tests++;
    if (status !== 4'b1010) begin
      fails++;
      $display("FAIL status_load got %b want 1010", status);
    end
    sl = 1'b0; {v_in, c_in, n_in, z_in} = 4'b0101;
    tick();
    tests++;
    if (status !== 4'b1010) begin
      fails++;
      $display("FAIL status_hold got %b want 1010", status);
    end
    sl = 1'b1; {v_in, c_in, n_in, z_in} = 4'b0110;
    rw = 1'b1; da = 3'd6; md = 1'b0; f_data = 16'h6666;
    tick();
    sl = 1'b0; rw = 1'b0; aa = 3'd6;
    #1;
    tests++;
    if (status !== 4'b0110 || bus_a !== 16'h6666) begin
      fails++;
      $display("FAIL status_with_rw got st=%b a=%h want 0110 6666", status, bus_a);
    end
  endtask

  task automatic test_rw_off();
    rw = 1'b0; da = 3'bxxx; md = 1'bx; f_data = 16'h9999; data_in = 16'h9999;
    tick();
    aa = 3'd3; ba = 3'd5; mb = 1'b0;
    #1;
    tests++;
    if (bus_a !== 16'h1234 || bus_b !== 16'h00AA) begin
      fails++;
      $display("FAIL rw_off got a=%h b=%h want 1234 00aa", bus_a, bus_b);
    end
  endtask

  task automatic test_r0();
    rw = 1'b1; da = 3'd0; md = 1'b0; f_data = 16'h5555;
    tick();
    rw = 1'b0; aa = 3'd0; ba = 3'd0; mb = 1'b0;
    #1;
    tests++;
    if (bus_a0 !== 16'h0000 || bus_b0 !== 16'h0000 || data_out0 !== 16'h0000) begin
      fails++;
      $display("FAIL r0_hw_read got a=%h b=%h d=%h want 0000", bus_a0, bus_b0, data_out0);
    end
    tests++;
    if (bus_a !== 16'h5555) begin
      fails++;
      $display("FAIL r0_plain_read got %h want 5555", bus_a);
    end
    mb = 1'b1; const_in = 16'h00C3;
    #1;
    tests++;
    if (bus_b0 !== 16'h00C3) begin
      fails++;
      $display("FAIL r0_hw_const got %h want 00c3", bus_b0);
    end
    aa = 3'd3; ba = 3'd2; mb = 1'b0;
    #1;
    tests++;
    if (bus_a0 !== 16'h1234 || bus_b0 !== 16'hBEEF) begin
      fails++;
      $display("FAIL r0_hw_others got a=%h b=%h want 1234 beef", bus_a0, bus_b0);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; rw = 1'b0; da = '0; aa = '0; ba = '0; mb = 1'b0;
    const_in = '0; md = 1'b0; f_data = '0; data_in = '0; sl = 1'b0;
    v_in = 1'b0; c_in = 1'b0; n_in = 1'b0; z_in = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_hazard();
    test_mux();
    test_status();
    test_rw_off();
    test_r0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
